// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: default data widths
// and the instruction presented when the queue has nothing to offer.
package fetch_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  // addi x0, x0, 0 -- canonical NOP shown on fetch_out while the queue is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Build an entry word with the instruction in the upper bits and the PC below.
  function automatic logic [63:0] pack_probe(input logic [31:0] instr, input logic [31:0] pc);
    return {instr, pc};
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port at the tail
// and an asynchronous read of the head. Contents are never reset; validity
// is tracked entirely by the pointer/count logic in fetch_queue.
module fetch_queue_mem #(
  parameter int ENTRY_W = 64,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  // Next array contents: only the addressed tail slot changes on a write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_ptr] = wr_data;
    end
  end

  // Storage register; deliberately without reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO of {instruction, PC} pairs
// between the fetch unit and decode. Flush has priority over push and pop.
// in_ready depends only on occupancy, so a full queue never passes through.
// Optional build macro FETCH_QUEUE_STATS_EN adds a saturating stall counter
// (stall_cnt) that counts cycles where upstream offers an entry while full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        instr_in,
  input  logic [ADDR_WIDTH-1:0]   pc_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        fetch_out,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int ENTRY_W = WIDTH + ADDR_WIDTH;

  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] NOP_W   = WIDTH'(NOP_INSTR);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head_entry;

  // Handshake flags derived from occupancy only.
  always_comb begin
    in_ready  = (count_q < DEPTH_C);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // Pointer and occupancy update; flush clears everything and drops any push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_q),
    .wr_data ({instr_in, pc_in}),
    .rd_ptr  (rd_ptr_q),
    .rd_data (head_entry)
  );

  // Head presentation: NOP and PC 0 whenever the queue is empty.
  always_comb begin
    count = count_q;
    if (out_valid) begin
      fetch_out = head_entry[ENTRY_W-1:ADDR_WIDTH];
      pc_out    = head_entry[ADDR_WIDTH-1:0];
    end else begin
      fetch_out = NOP_W;
      pc_out    = '0;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where upstream is blocked; flush does not clear it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, PC width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, number of entries; legal values are powers of two, 2 or more.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port instr_in  input  WIDTH  fetched instruction.
REQ-007 SHALL have port pc_in  input  ADDR_WIDTH  PC of instr_in.
REQ-008 SHALL have port in_valid  input  1  upstream offers an entry.
REQ-009 SHALL have port in_ready  output  1  queue accepts an entry.
REQ-010 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-011 SHALL have port fetch_out  output  WIDTH  head instruction.
REQ-012 SHALL have port pc_out  output  ADDR_WIDTH  head PC.
REQ-013 SHALL have port out_valid  output  1  head entry valid.
REQ-014 SHALL have port out_ready  input  1  downstream consumes the head.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL push {instr_in, pc_in} at the tail on a rising edge where in_valid && in_ready && !flush.
REQ-017 SHALL pop the head on a rising edge where out_valid && out_ready && !flush.
REQ-018 SHALL drive in_ready = (count < DEPTH), combinational from state only, with no dependence on out_ready (no full-queue pass-through).
REQ-019 SHALL drive out_valid = (count != 0).
REQ-020 SHALL drive fetch_out = head instruction when out_valid, else NOP (32'h00000013 zero-extended or truncated to WIDTH); pc_out = head PC when valid, else 0.
REQ-021 SHALL have a latency of one cycle: an entry pushed at edge N appears on fetch_out after edge N when the queue was empty.
REQ-022 SHALL leave count unchanged on simultaneous push and pop; a push alone increments count, a pop alone decrements it.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH, with no lost or duplicated entries across the wrap.
REQ-024 SHALL give flush priority over push and pop: on the next edge, count = 0 and pointers = 0, and any concurrent push is dropped.
REQ-025 SHALL preserve strict FIFO order of pushed entries.
REQ-026 SHALL ignore in_valid while full and out_ready while empty, with no state change.

Reset
REQ-027 SHALL, while rst = 0 and independent of clk, force count = 0 and both pointers = 0, giving out_valid = 0, in_ready = 1, fetch_out = NOP and pc_out = 0.
REQ-028 SHALL discard all contents on reset asserted mid-operation; storage array contents need not be cleared.
REQ-029 SHALL accept the first push on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with FETCH_QUEUE_STATS_EN defined, add output stall_cnt [15:0] counting cycles with in_valid && !in_ready; it saturates at 16'hFFFF, is cleared only by reset (not by flush), and resets to 0.
REQ-031 SHALL, without FETCH_QUEUE_STATS_EN, omit the stall_cnt port and all related logic.

Structure
REQ-032 SHALL take the NOP_INSTR constant and the default WIDTH/ADDR_WIDTH values from shared package fetch_pkg.
REQ-033 SHALL place entry storage (write port and asynchronous read of the head) in sub-module fetch_queue_mem; pointer, count and handshake control stay in fetch_queue.

Verification
REQ-034 SHALL verify: after reset, push 32'h05002030 at PC 0x0 with out_ready = 0 -> next cycle out_valid = 1, fetch_out = 32'h05002030, count = 1.
REQ-035 SHALL verify: DEPTH = 4, push 5 entries 32'h11111111..32'h55555555 with out_ready = 0 -> in_ready = 0 after the 4th push, 5th entry dropped, pops return 11111111..44444444 in order.
REQ-036 SHALL verify: continuous push and pop for 10 cycles with count = 2 -> count stays 2, outputs in order, correct across pointer wrap.
REQ-037 SHALL verify: queue with 3 entries, flush = 1 together with in_valid = 1 -> next cycle count = 0, out_valid = 0, fetch_out = 32'h00000013, pushed entry absent.
REQ-038 SHALL verify: rst driven low between clock edges with 2 entries queued -> out_valid = 0 and count = 0 immediately, without waiting for a clock edge.
REQ-039 SHALL verify, with FETCH_QUEUE_STATS_EN: hold the queue full with in_valid = 1 for 7 cycles -> stall_cnt = 7; a following flush leaves stall_cnt = 7.
